// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch unit: ALU opcodes, major opcodes,
// FSM state encoding and the funct7 legality rule.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_WB     = 2'b11
  } state_e;

  // I-type non-shift ops carry immediate bits in funct7, so they are always legal.
  function automatic logic funct7_legal(input logic is_rtype, input logic [2:0] funct3,
                                        input logic [6:0] funct7);
    logic ok;
    ok = 1'b0;
    if (!is_rtype && funct3 != ALU_SLL && funct3 != ALU_SR) begin
      ok = 1'b1;
    end else if (funct7 == F7_BASE) begin
      ok = 1'b1;
    end else if (funct7 == F7_ALT) begin
      ok = (funct3 == ALU_SR) || (is_rtype && funct3 == ALU_ADD);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two async read ports, one write port, x0 hardwired
// to zero. A third (debug) read port exists when ALU_DISPATCH_DBG_EN is defined.
module alu_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
`ifdef ALU_DISPATCH_DBG_EN
  ,
  input  logic [4:0]      raddr3,
  output logic [XLEN-1:0] rdata3
`endif
);

  logic [XLEN-1:0] regs_r [NREG];

  // Storage; writes to x0 are dropped so it always reads back as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read ports
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) rdata1 = regs_r[raddr1];
    else rdata1 = '0;
    if (raddr2 != 5'd0) rdata2 = regs_r[raddr2];
    else rdata2 = '0;
  end

`ifdef ALU_DISPATCH_DBG_EN
  // Debug read port
  always_comb begin
    rdata3 = '0;
    if (raddr3 != 5'd0) rdata3 = regs_r[raddr3];
    else rdata3 = '0;
  end
`endif

endmodule

// File: rtl/alu_dispatch.sv
// Decodes RV32 R/I-type ALU instructions, drives an external ALU and writes back.
// Optional debug register read port: define ALU_DISPATCH_DBG_EN.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [2:0]      alu_opcode,
  output logic            alu_is_signed,
  input  logic [XLEN-1:0] alu_res,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal
`ifdef ALU_DISPATCH_DBG_EN
  ,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
`endif
);

  state_e          state_r;
  logic [31:0]     instr_r;
  logic [XLEN-1:0] res_r;
  logic [XLEN-1:0] rs1_data_s, rs2_data_s, base_op2_s, op2_s;
  logic            is_rtype_s, legal_s, sgn_s, we_s;
  logic [2:0]      opc_s;

  assign instr_ready = (state_r == ST_IDLE);
  assign we_s        = (state_r == ST_WB);

  alu_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (instr_r[19:15]),
    .rdata1 (rs1_data_s),
    .raddr2 (instr_r[24:20]),
    .rdata2 (rs2_data_s),
    .we     (we_s),
    .waddr  (instr_r[11:7]),
    .wdata  (res_r)
`ifdef ALU_DISPATCH_DBG_EN
    ,
    .raddr3 (dbg_raddr),
    .rdata3 (dbg_rdata)
`endif
  );

  // Decode: the ALU opcode equals funct3; funct7 bit 30 selects SUB / arithmetic shift.
  always_comb begin
    is_rtype_s = (instr_r[6:0] == OPC_RTYPE);
    opc_s      = instr_r[14:12];
    legal_s    = 1'b0;
    base_op2_s = rs2_data_s;
    op2_s      = rs2_data_s;
    sgn_s      = 1'b0;
    if (is_rtype_s || instr_r[6:0] == OPC_ITYPE) legal_s = funct7_legal(is_rtype_s, opc_s, instr_r[31:25]);
    else legal_s = 1'b0;
    if (is_rtype_s) base_op2_s = rs2_data_s;
    else base_op2_s = {{(XLEN-12){instr_r[31]}}, instr_r[31:20]};
    case (opc_s)
      ALU_ADD: begin
        if (is_rtype_s && instr_r[30]) op2_s = ~rs2_data_s + {{(XLEN-1){1'b0}}, 1'b1};
        else op2_s = base_op2_s;
        sgn_s = 1'b0;
      end
      ALU_SLL: begin
        op2_s = {{(XLEN-5){1'b0}}, base_op2_s[4:0]};
        sgn_s = 1'b0;
      end
      ALU_SLT: begin
        op2_s = base_op2_s;
        sgn_s = 1'b1;
      end
      ALU_SR: begin
        op2_s = {{(XLEN-5){1'b0}}, base_op2_s[4:0]};
        sgn_s = instr_r[30];
      end
      default: begin
        op2_s = base_op2_s;
        sgn_s = 1'b0;
      end
    endcase
  end

  // Dispatch FSM with registered ALU drive, writeback report and illegal pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      instr_r       <= 32'd0;
      res_r         <= '0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      alu_opcode    <= 3'd0;
      alu_is_signed <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= '0;
      illegal       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_r <= instr;
            state_r <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (legal_s) begin
            alu_op1       <= rs1_data_s;
            alu_op2       <= op2_s;
            alu_opcode    <= opc_s;
            alu_is_signed <= sgn_s;
            state_r       <= ST_EXEC;
          end else begin
            illegal <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          res_r   <= alu_res;
          state_r <= ST_WB;
        end
        ST_WB: begin
          wb_valid <= 1'b1;
          wb_rd    <= instr_r[11:7];
          wb_data  <= res_r;
          state_r  <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: acts as the ALU, predicts every writeback from ISA
// semantics on a register-array model, and drives directed plus random instructions.
module tb_alu_dispatch;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] alu_op1, alu_op2, alu_res;
  logic [2:0]      alu_opcode;
  logic            alu_is_signed;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;
`ifdef ALU_DISPATCH_DBG_EN
  logic [XLEN-1:0] dbg_rdata;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic [31:0] last_wb, last_op2;
  logic [2:0]  last_opc;
  logic        last_sgn;

  typedef struct packed {
    logic        legal;
    logic [31:0] res;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  opc;
    logic        sgn;
  } exp_t;

  alu_dispatch #(.XLEN(XLEN), .NREG(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_opcode    (alu_opcode),
    .alu_is_signed (alu_is_signed),
    .alu_res       (alu_res),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .illegal       (illegal)
`ifdef ALU_DISPATCH_DBG_EN
    ,
    .dbg_raddr     (5'd0),
    .dbg_rdata     (dbg_rdata)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU attached to the DUT
  logic [XLEN-1:0] sra_res;
  assign sra_res = $signed(alu_op1) >>> alu_op2[4:0];
  always_comb begin
    case (alu_opcode)
      3'd0:    alu_res = alu_op1 + alu_op2;
      3'd1:    alu_res = alu_op1 << alu_op2[4:0];
      3'd2:    alu_res = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      3'd3:    alu_res = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
      3'd4:    alu_res = alu_op1 ^ alu_op2;
      3'd5:    alu_res = alu_is_signed ? sra_res : (alu_op1 >> alu_op2[4:0]);
      3'd6:    alu_res = alu_op1 | alu_op2;
      default: alu_res = alu_op1 & alu_op2;
    endcase
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // ISA-level prediction from the current architectural register model
  function automatic exp_t predict(input logic [31:0] ins);
    exp_t e;
    logic [31:0] a, b, sra;
    logic [4:0]  sh;
    logic        is_r, is_i, alt, sub;
    logic [2:0]  f3;
    f3   = ins[14:12];
    is_r = (ins[6:0] == 7'b0110011);
    is_i = (ins[6:0] == 7'b0010011);
    alt  = (ins[31:25] == 7'b0100000);
    a    = model[ins[19:15]];
    b    = is_r ? model[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
    sh   = b[4:0];
    sub  = is_r && alt && (f3 == 3'd0);
    if (is_r) e.legal = (ins[31:25] == 7'd0) || (alt && (f3 == 3'd0 || f3 == 3'd5));
    else if (is_i && f3 == 3'd1) e.legal = (ins[31:25] == 7'd0);
    else if (is_i && f3 == 3'd5) e.legal = (ins[31:25] == 7'd0) || alt;
    else e.legal = is_i;
    sra = $signed(a) >>> sh;
    case (f3)
      3'd0:    e.res = sub ? a - b : a + b;
      3'd1:    e.res = a << sh;
      3'd2:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    e.res = (a < b) ? 32'd1 : 32'd0;
      3'd4:    e.res = a ^ b;
      3'd5:    e.res = alt ? sra : (a >> sh);
      3'd6:    e.res = a | b;
      default: e.res = a & b;
    endcase
    e.op1 = a;
    e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, sh} : (sub ? 32'd0 - b : b);
    e.opc = f3;
    e.sgn = (f3 == 3'd2) || (f3 == 3'd5 && alt);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction, sampled on falling edges; hold keeps instr_valid high in flight.
  task automatic run(input logic [31:0] ins, input bit hold);
    exp_t e;
    int   n;
    e = predict(ins);
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", instr_ready, 1'b1);
    instr       = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    if (hold) instr = ~ins;
    else instr_valid = 1'b0;
    chk("ready_decode", instr_ready, 1'b0);
    @(negedge clk);
    chk("illegal", illegal, !e.legal);
    if (e.legal) begin
      chk("alu_op1", alu_op1, e.op1);
      chk("alu_op2", alu_op2, e.op2);
      chk("alu_opcode", alu_opcode, e.opc);
      chk("alu_is_signed", alu_is_signed, e.sgn);
      chk("ready_exec", instr_ready, 1'b0);
      last_op2 = alu_op2;
      last_opc = alu_opcode;
      last_sgn = alu_is_signed;
      @(negedge clk);
      chk("wb_early", wb_valid, 1'b0);
      chk("alu_hold", alu_op2, e.op2);
      @(negedge clk);
      instr_valid = 1'b0;
      chk("wb_valid", wb_valid, 1'b1);
      chk("wb_rd", wb_rd, ins[11:7]);
      chk("wb_data", wb_data, e.res);
      chk("ready_after_wb", instr_ready, 1'b1);
      last_wb = wb_data;
      if (ins[11:7] != 5'd0) model[ins[11:7]] = e.res;
      @(negedge clk);
      chk("wb_pulse_end", wb_valid, 1'b0);
      chk("no_extra_capture", instr_ready, 1'b1);
    end else begin
      chk("illegal_no_wb", wb_valid, 1'b0);
      instr_valid = 1'b0;
      @(negedge clk);
      chk("illegal_pulse_end", illegal, 1'b0);
      chk("illegal_no_wb2", wb_valid, 1'b0);
      chk("ready_after_illegal", instr_ready, 1'b1);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) model[r] = 32'd0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_alu_op2", alu_op2, 32'd0);
    chk("rst_illegal", illegal, 1'b0);
    rst = 1'b0;
    chk("rst_ready", instr_ready, 1'b1);

    // Basic add chain
    run(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 1'b0);
    chk("addi_5", last_wb, 32'd5);
    run(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 1'b0);
    chk("addi_m3", last_wb, 32'hFFFFFFFD);
    run(enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3), 1'b0);
    chk("add_x3", last_wb, 32'd2);

    // SUB / SLT / SLTU
    run(enc_i(12'd7, 5'd0, 3'd0, 5'd2), 1'b0);
    run(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 1'b0);
    chk("sub_x4", last_wb, 32'hFFFFFFFE);
    run(enc_r(7'd0, 5'd2, 5'd1, 3'd2, 5'd5), 1'b0);
    chk("slt_opc", {last_opc, last_sgn}, {3'b010, 1'b1});
    chk("slt_res", last_wb, 32'd1);
    run(enc_r(7'd0, 5'd1, 5'd2, 3'd3, 5'd6), 1'b0);
    chk("sltu_opc", {last_opc, last_sgn}, {3'b011, 1'b0});
    chk("sltu_res", last_wb, 32'd0);

    // Shifts on 0x80000000
    run(enc_i(12'd1, 5'd0, 3'd0, 5'd1), 1'b0);
    run(enc_i({7'd0, 5'd31}, 5'd1, 3'd1, 5'd1), 1'b0);
    chk("slli_31", last_wb, 32'h80000000);
    run(enc_i({7'h20, 5'd4}, 5'd1, 3'd5, 5'd7), 1'b0);
    chk("srai_ctl", {last_opc, last_sgn, last_op2}, {3'b101, 1'b1, 32'd4});
    chk("srai_res", last_wb, 32'hF8000000);
    run(enc_i({7'd0, 5'd4}, 5'd1, 3'd5, 5'd10), 1'b0);
    chk("srli_sgn", last_sgn, 1'b0);
    chk("srli_res", last_wb, 32'h08000000);
    run(enc_i(12'h024, 5'd0, 3'd0, 5'd2), 1'b0);
    run(enc_r(7'd0, 5'd2, 5'd1, 3'd1, 5'd8), 1'b0);
    chk("sll_op2", last_op2, 32'd4);

    // x0 write is discarded but still reported
    run(enc_i(12'd9, 5'd0, 3'd0, 5'd0), 1'b0);
    chk("x0_wb_data", last_wb, 32'd9);
    run(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd11), 1'b0);
    chk("x0_reads_zero", last_wb, 32'd0);

    // Illegal encodings, then an instruction with instr_valid held throughout
    run(32'h00000063, 1'b0);
    run(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd13), 1'b1);
    run(enc_i({7'h20, 5'd3}, 5'd1, 3'd1, 5'd13), 1'b0);
    run(enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd14), 1'b1);

    // Random mix of legal and illegal instructions
    for (int k = 0; k < 150; k++) begin
      int          kind;
      logic [6:0]  f7;
      logic [31:0] ins;
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'd0;
        2:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      if (kind < 5) ins = enc_r(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
      else if (kind < 9) ins = enc_i({f7, 5'($urandom)}, 5'($urandom), 3'($urandom), 5'($urandom));
      else ins = $urandom;
      run(ins, k[0]);
    end

    // Read back the whole register file through rd=0 adds
    for (int r = 0; r < 32; r++) run(enc_r(7'd0, 5'd0, 5'(r), 3'd0, 5'd0), 1'b0);

    // Reset while in EXEC abandons the instruction
    run(enc_i(12'd100, 5'd0, 3'd0, 5'd15), 1'b0);
    instr       = enc_i(12'd77, 5'd0, 3'd0, 5'd9);
    instr_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_op2", alu_op2, 32'd77);
    rst = 1'b1;
    #1;
    chk("rst_async_op2", alu_op2, 32'd0);
    chk("rst_async_opc", alu_opcode, 3'd0);
    chk("rst_async_wb_data", wb_data, 32'd0);
    chk("rst_async_wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b0;
    for (int r = 0; r < 32; r++) model[r] = 32'd0;
    chk("ready_after_rst", instr_ready, 1'b1);
    run(enc_r(7'd0, 5'd0, 5'd9, 3'd0, 5'd0), 1'b0);
    chk("x9_not_written", last_wb, 32'd0);
    run(enc_r(7'd0, 5'd0, 5'd15, 3'd0, 5'd0), 1'b0);
    chk("x15_cleared", last_wb, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
